// File: rtl/bilinear_fetch_sched.sv
// Fetches the 2x2 neighbourhood of one fixed-point coordinate and emits one pixelx4/decimal beat.
// Optional macro PIX_STATS_EN adds the px_count/oob_count statistics outputs.
module bilinear_fetch_sched #(
  parameter int unsigned IMG_W    = 640,
  parameter int unsigned IMG_H    = 480,
  parameter int unsigned ADDR_W   = 19,
  parameter int unsigned RD_LAT   = 2,
  parameter int unsigned CREDITS  = 8,
  parameter logic [15:0] BG_PIXEL = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              coord_valid,
  output logic              coord_ready,
  input  logic [17:0]       coord_x,
  input  logic [17:0]       coord_y,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [15:0]       rd_data,
  output logic [63:0]       pixelx4,
  output logic [15:0]       decimal,
  output logic              pixelx4_valid,
  input  logic              fifo_pop,
  output logic              busy,
`ifdef PIX_STATS_EN
  output logic [31:0]       px_count,
  output logic [15:0]       oob_count,
`endif
  output logic              credit_err
);

  localparam int unsigned INT_W  = 10;
  localparam int unsigned FRAC_W = 8;
  localparam int unsigned CRED_W = 4;
  localparam int unsigned TAG_W  = 3;
  localparam logic [INT_W-1:0]  X_LAST   = INT_W'(IMG_W - 1);
  localparam logic [INT_W-1:0]  Y_LAST   = INT_W'(IMG_H - 1);
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(CREDITS);

  typedef enum logic [2:0] {IDLE, ADDR, ISSUE, WAIT, EMIT} state_t;

  state_t              state;
  logic [INT_W-1:0]    xi, yi;
  logic [FRAC_W-1:0]   xf, yf;
  logic [ADDR_W-1:0]   base, dx, dy;
  logic [ADDR_W-1:0]   base_c;
  logic                oob_c;
  logic [1:0]          idx;
  logic [TAG_W-1:0]    tag_pipe [RD_LAT];
  logic [TAG_W-1:0]    tag_out;
  logic [3:0][15:0]    slot;
  logic [CRED_W-1:0]   credits;
  logic                emit;

  assign base_c      = ADDR_W'(yi) * ADDR_W'(IMG_W) + ADDR_W'(xi);
  assign oob_c       = (32'(xi) >= IMG_W) || (32'(yi) >= IMG_H);
  assign tag_out     = tag_pipe[RD_LAT-1];
  assign emit        = (state == EMIT);
  assign coord_ready = (state == IDLE) && (credits != '0) && !rst;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      xi            <= '0;
      yi            <= '0;
      xf            <= '0;
      yf            <= '0;
      base          <= '0;
      dx            <= '0;
      dy            <= '0;
      idx           <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) tag_pipe[i] <= '0;
      slot          <= '0;
      credits       <= CRED_MAX;
      credit_err    <= 1'b0;
      rd_en         <= 1'b0;
      rd_addr       <= '0;
      pixelx4       <= '0;
      decimal       <= '0;
      pixelx4_valid <= 1'b0;
    end else begin
      pixelx4_valid <= 1'b0;

      // Tag travels alongside the read so returning data lands in its slot.
      tag_pipe[0] <= {rd_en, idx};
      for (int unsigned i = 1; i < RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
      if (tag_out[2]) slot[tag_out[1:0]] <= rd_data;

      // A credit is consumed on emit and returned by a pop; a pop at full is an error.
      if (emit && !fifo_pop) begin
        credits <= credits - CRED_W'(1);
      end else if (!emit && fifo_pop) begin
        if (credits == CRED_MAX) credit_err <= 1'b1;
        else                     credits    <= credits + CRED_W'(1);
      end

      case (state)
        IDLE: begin
          if (coord_valid && coord_ready) begin
            xi    <= coord_x[17:8];
            yi    <= coord_y[17:8];
            xf    <= coord_x[7:0];
            yf    <= coord_y[7:0];
            state <= ADDR;
          end
        end
        ADDR: begin
          base <= base_c;
          dx   <= (xi == X_LAST) ? '0 : ADDR_W'(1);
          dy   <= (yi == Y_LAST) ? '0 : ADDR_W'(IMG_W);
          if (oob_c) begin
            pixelx4       <= {4{BG_PIXEL}};
            decimal       <= '0;
            pixelx4_valid <= 1'b1;
            state         <= EMIT;
          end else begin
            rd_en   <= 1'b1;
            rd_addr <= base_c;
            idx     <= '0;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          idx <= idx + 2'd1;
          if (idx == 2'd3) begin
            rd_en <= 1'b0;
            state <= WAIT;
          end else begin
            case (idx)
              2'd0:    rd_addr <= base + dx;
              2'd1:    rd_addr <= base + dy;
              default: rd_addr <= base + dy + dx;
            endcase
          end
        end
        WAIT: begin
          // Last neighbour is taken straight from the read port as it arrives.
          if (tag_out[2] && tag_out[1:0] == 2'd3) begin
            pixelx4       <= {rd_data, slot[2], slot[1], slot[0]};
            decimal       <= {xf, yf};
            pixelx4_valid <= 1'b1;
            state         <= EMIT;
          end
        end
        EMIT:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PIX_STATS_EN
  logic oob_pend;

  // Saturating emit statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oob_pend  <= 1'b0;
      px_count  <= '0;
      oob_count <= '0;
    end else begin
      if (state == ADDR) oob_pend <= oob_c;
      if (pixelx4_valid && px_count != '1) px_count <= px_count + 32'd1;
      if (pixelx4_valid && oob_pend && oob_count != '1) oob_count <= oob_count + 16'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_bilinear_fetch_sched.sv
// Self-checking bench for bilinear_fetch_sched: directed corner cases plus randomized coordinates
// against a neighbourhood/credit reference model.
module tb_bilinear_fetch_sched;

  localparam int unsigned W   = 640;
  localparam int unsigned H   = 480;
  localparam int unsigned AW  = 19;
  localparam int unsigned RDL = 2;
  localparam int unsigned CR  = 8;
  localparam logic [15:0] BG  = 16'hF800;

  logic          clk;
  logic          rst;
  logic          coord_valid;
  logic          coord_ready;
  logic [17:0]   coord_x;
  logic [17:0]   coord_y;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [15:0]   rd_data;
  logic [63:0]   pixelx4;
  logic [15:0]   decimal;
  logic          pixelx4_valid;
  logic          fifo_pop;
  logic          busy;
  logic          credit_err;

  bilinear_fetch_sched #(
    .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .RD_LAT(RDL), .CREDITS(CR), .BG_PIXEL(BG)
  ) dut (
    .clk(clk), .rst(rst),
    .coord_valid(coord_valid), .coord_ready(coord_ready),
    .coord_x(coord_x), .coord_y(coord_y),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .pixelx4(pixelx4), .decimal(decimal), .pixelx4_valid(pixelx4_valid),
    .fifo_pop(fifo_pop), .busy(busy), .credit_err(credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          model_cred;
  logic        model_err;
  int unsigned cyc = 0;
  logic [15:0] key = 16'h0000;
  logic [16:0] mp [RDL];
  int unsigned rd_q [$];
  int unsigned rc_q [$];

  // Frame-buffer model: word = address[15:0] ^ key, returned RDL cycles after the strobe.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en) begin
      rd_q.push_back(32'(rd_addr));
      rc_q.push_back(cyc);
    end
    mp[0] <= {rd_en, rd_addr[15:0] ^ key};
    for (int i = 1; i < RDL; i++) mp[i] <= mp[i-1];
  end
  assign rd_data = mp[RDL-1][16] ? mp[RDL-1][15:0] : 16'hDEAD;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mw(input int unsigned a);
    logic [31:0] t;
    t = a;
    return t[15:0] ^ key;
  endfunction

  // Neighbourhood with edge clamping, written as min() on the integer coordinates.
  task automatic ref_model(input logic [17:0] x, input logic [17:0] y, output logic oob,
                           output logic [3:0][31:0] a, output logic [63:0] px,
                           output logic [15:0] dec);
    int unsigned xi, yi, x1, y1;
    xi  = 32'(x[17:8]);
    yi  = 32'(y[17:8]);
    oob = (xi >= W) || (yi >= H);
    x1  = (xi + 1 > W - 1) ? W - 1 : xi + 1;
    y1  = (yi + 1 > H - 1) ? H - 1 : yi + 1;
    a[0] = yi * W + xi;
    a[1] = yi * W + x1;
    a[2] = y1 * W + xi;
    a[3] = y1 * W + x1;
    px  = oob ? {4{BG}} : {mw(a[3]), mw(a[2]), mw(a[1]), mw(a[0])};
    dec = oob ? 16'h0000 : {x[7:0], y[7:0]};
  endtask

  task automatic do_request(input logic [17:0] x, input logic [17:0] y);
    logic oob;
    logic [3:0][31:0] a;
    logic [63:0] px;
    logic [15:0] dec;
    int n, lat;
    int unsigned acc;
    ref_model(x, y, oob, a, px, dec);
    @(negedge clk);
    rd_q.delete();
    rc_q.delete();
    coord_valid = 1'b1;
    coord_x = x;
    coord_y = y;
    n = 0;
    while (!coord_ready && n < 40) begin @(negedge clk); n++; end
    check("accept", 64'(coord_ready), 64'(1));
    acc = cyc;
    @(negedge clk);
    coord_valid = 1'b0;
    coord_x = 18'($urandom);
    coord_y = 18'($urandom);
    check("busy", 64'(busy), 64'(1));
    lat = 1;
    while (!pixelx4_valid && lat < 30) begin @(negedge clk); lat++; end
    check("latency", 64'(lat), oob ? 64'(2) : 64'(RDL + 6));
    check("pixelx4", pixelx4, px);
    check("decimal", 64'(decimal), 64'(dec));
    check("n_reads", 64'(rd_q.size()), oob ? 64'(0) : 64'(4));
    for (int i = 0; i < rd_q.size() && i < 4; i++) begin
      check("rd_addr", 64'(rd_q[i]), 64'(a[i]));
      check("rd_cycle", 64'(rc_q[i]), 64'(acc + 2 + 32'(i)));
    end
    model_cred--;
    @(negedge clk);
    check("strobe_width", 64'(pixelx4_valid), 64'(0));
    check("ready_after", 64'(coord_ready), 64'(model_cred != 0));
  endtask

  task automatic pop_one;
    @(negedge clk);
    fifo_pop = 1'b1;
    @(negedge clk);
    fifo_pop = 1'b0;
    if (model_cred == CR) model_err = 1'b1;
    else model_cred++;
  endtask

  task automatic count_strobes(input logic [17:0] x, input logic [17:0] y, input int ncyc,
                               output int n);
    logic oob;
    logic [3:0][31:0] a;
    logic [63:0] px;
    logic [15:0] dec;
    ref_model(x, y, oob, a, px, dec);
    @(negedge clk);
    coord_valid = 1'b1;
    coord_x = x;
    coord_y = y;
    n = 0;
    repeat (ncyc) begin
      @(negedge clk);
      if (pixelx4_valid) begin
        n++;
        check("held_px", pixelx4, px);
      end
    end
    coord_valid = 1'b0;
  endtask

  function automatic logic [9:0] pick(input int unsigned last);
    int unsigned r;
    r = $urandom_range(0, 4);
    case (r)
      0:       return 10'd0;
      1:       return 10'(last);
      2:       return 10'($urandom_range(last + 1, 1023));
      default: return 10'($urandom_range(0, last));
    endcase
  endfunction

  initial begin
    int n, k;
    logic [17:0] rx, ry;
    rst = 1'b1;
    coord_valid = 1'b0;
    coord_x = '0;
    coord_y = '0;
    fifo_pop = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(coord_ready), 64'(0));
    check("rst_rd_en", 64'(rd_en), 64'(0));
    check("rst_rd_addr", 64'(rd_addr), 64'(0));
    check("rst_valid", 64'(pixelx4_valid), 64'(0));
    check("rst_pixelx4", pixelx4, 64'(0));
    check("rst_decimal", 64'(decimal), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_credit_err", 64'(credit_err), 64'(0));
    rst = 1'b0;
    #1;
    check("ready_out_of_reset", 64'(coord_ready), 64'(1));
    model_cred = CR;
    model_err = 1'b0;

    // Interior, corner clamp and out-of-range samples.
    key = 16'h0000;
    do_request(18'h00A80, 18'h01440);
    pop_one();
    do_request({10'd639, 8'hFF}, {10'd479, 8'hFF});
    pop_one();
    do_request({10'd640, 8'h00}, 18'h01440);
    pop_one();

    // Randomized coordinates, biased toward edges and out-of-range values.
    for (int i = 0; i < 16; i++) begin
      key = 16'($urandom);
      rx = {pick(W - 1), 8'($urandom)};
      ry = {pick(H - 1), 8'($urandom)};
      do_request(rx, ry);
      pop_one();
    end

    // Credit exhaustion with coord_valid held and no pops.
    key = 16'($urandom);
    count_strobes({10'd100, 8'h11}, {10'd200, 8'h22}, 100, n);
    check("exhaust_strobes", 64'(n), 64'(CR));
    model_cred = 0;
    @(negedge clk);
    check("exhaust_blocked", 64'(coord_ready), 64'(0));
    @(negedge clk);
    fifo_pop = 1'b1;
    @(negedge clk);
    fifo_pop = 1'b0;
    check("pop_reopens", 64'(coord_ready), 64'(1));
    model_cred = 1;

    // Pop coincident with the emit cycle leaves credits unchanged.
    @(negedge clk);
    coord_valid = 1'b1;
    coord_x = {10'd5, 8'h01};
    coord_y = {10'd6, 8'h02};
    k = 0;
    while (!coord_ready && k < 40) begin @(negedge clk); k++; end
    @(negedge clk);
    coord_valid = 1'b0;
    k = 0;
    while (!pixelx4_valid && k < 30) begin @(negedge clk); k++; end
    check("coinc_emit_seen", 64'(pixelx4_valid), 64'(1));
    fifo_pop = 1'b1;
    @(negedge clk);
    fifo_pop = 1'b0;
    check("coinc_ready", 64'(coord_ready), 64'(1));
    do_request({10'd7, 8'h03}, {10'd8, 8'h04});
    repeat (CR) pop_one();
    check("no_credit_err", 64'(credit_err), 64'(model_err));

    // Pop at full credits is flagged and does not overfill.
    pop_one();
    check("credit_err_set", 64'(credit_err), 64'(model_err));
    count_strobes({10'd300, 8'hA5}, {10'd100, 8'h5A}, 100, n);
    check("full_strobes", 64'(n), 64'(CR));
    check("credit_err_sticky", 64'(credit_err), 64'(1));
    model_cred = 0;
    repeat (CR) pop_one();

    // Reset while waiting for the last read return.
    key = 16'($urandom);
    @(negedge clk);
    coord_valid = 1'b1;
    coord_x = {10'd50, 8'h10};
    coord_y = {10'd60, 8'h20};
    k = 0;
    while (!coord_ready && k < 40) begin @(negedge clk); k++; end
    @(negedge clk);
    coord_valid = 1'b0;
    n = 0;
    k = 0;
    while (n < 4 && k < 20) begin @(negedge clk); k++; if (rd_en) n++; end
    check("abort_reads_seen", 64'(n), 64'(4));
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_rd_en", 64'(rd_en), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_ready", 64'(coord_ready), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    model_cred = CR;
    model_err = 1'b0;
    n = 0;
    repeat (15) begin @(negedge clk); if (pixelx4_valid) n++; end
    check("abort_no_strobe", 64'(n), 64'(0));
    check("abort_err_clear", 64'(credit_err), 64'(0));
    check("abort_ready_after", 64'(coord_ready), 64'(1));
    count_strobes({10'd20, 8'h33}, {10'd30, 8'h44}, 100, n);
    check("abort_credits", 64'(n), 64'(CR));
    model_cred = 0;
    repeat (CR) pop_one();
    key = 16'($urandom);
    do_request({10'd51, 8'h77}, {10'd61, 8'h88});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bilinear_fetch_sched.md
Name: bilinear_fetch_sched

Overview:
Sequencer in front of the bilinear pixel filter. It accepts one fixed-point source coordinate per request and issues four reads to the frame-buffer read port for the 2x2 neighbourhood. It packs the returned pixels with the fractional weights into one pixelx4/decimal beat for the filter. The filter has no backpressure, so this block also holds a credit counter that guarantees the downstream write FIFO never overflows.

Parameters:
IMG_W, 640, image width in pixels; the line stride in words.
IMG_H, 480, image height in pixels.
ADDR_W, 19, read address width.
RD_LAT, 2, fixed read latency in cycles (1..4) from rd_en to rd_data.
CREDITS, 8, free slots reserved in the downstream FIFO (1..15).
BG_PIXEL, 16'h0000, RGB565 value used for out-of-range coordinates.

Ports:
clk  in  1  clock
rst  in  1  reset
coord_valid  in  1  request valid
coord_ready  out  1  request accepted when valid&&ready
coord_x  in  18  source x, unsigned 10.8 fixed point
coord_y  in  18  source y, unsigned 10.8 fixed point
rd_en  out  1  frame-buffer read strobe
rd_addr  out  ADDR_W  word address
rd_data  in  16  RGB565 pixel, valid RD_LAT cycles after rd_en
pixelx4  out  64  {p22,p21,p12,p11}, 16 bits each
decimal  out  16  {x_frac[7:0], y_frac[7:0]}; raw fractions, not inverted
pixelx4_valid  out  1  single-cycle strobe to the filter
fifo_pop  in  1  downstream FIFO consumed one pixel; returns one credit
busy  out  1  high whenever state != IDLE
credit_err  out  1  sticky: fifo_pop seen while credits == CREDITS

Behaviour:
- Reset: rst is asynchronous and active-high; clk is the clock. All outputs go to 0 (coord_ready=0 while rst is asserted). state=IDLE, credits=CREDITS, read-tag pipeline cleared. Read data arriving after reset is ignored.
- coord_ready = (state==IDLE) && (credits!=0) && !rst. It is combinational from registered state.
- xi=coord_x[17:8], yi=coord_y[17:8]. Fractions are coord_x[7:0] and coord_y[7:0], latched on accept.
- FSM states: IDLE, ADDR, ISSUE, WAIT, EMIT.
- IDLE to ADDR on accept (cycle T).
- ADDR (T+1) registers the following:
  - base = yi*IMG_W + xi;
  - dx = (xi==IMG_W-1) ? 0 : 1;
  - dy = (yi==IMG_H-1) ? 0 : IMG_W, so edge neighbours clamp to the edge pixel;
  - oob = (xi>=IMG_W) || (yi>=IMG_H).
  - If oob: go to EMIT.
  - Else: go to ISSUE.
- ISSUE (T+2..T+5): rd_en=1 for exactly 4 consecutive cycles. Addresses in order are base, base+dx, base+dy, base+dy+dx, tagged 0..3.
- A 3-bit tag shift register (valid + 2-bit index) delays each tag by RD_LAT. rd_data is captured into slot p11/p12/p21/p22 by tag 0/1/2/3.
- WAIT: hold until tag 3 is captured (T+5+RD_LAT), then go to EMIT.
- EMIT (T+6+RD_LAT):
  - pixelx4_valid=1 for one cycle; pixelx4 and decimal are driven from registers.
  - credits decrements.
  - Next state is IDLE.
  - Total accept-to-valid latency is RD_LAT+6. Next accept is earliest at EMIT+1.
- oob path: EMIT at T+2. pixelx4 = BG_PIXEL replicated ×4, decimal=16'h0000, no reads issued. A credit is still consumed.
- pixelx4, decimal and rd_addr hold their last value when not strobed. rd_addr = 0 after reset.
- Credits:
  - EMIT and fifo_pop in the same cycle leaves credits unchanged.
  - fifo_pop at credits==CREDITS is ignored (saturating) and sets credit_err, which is cleared only by rst.
  - credits==0 blocks accept; it never blocks a request already in flight, because the credit was checked at accept.
- coord_x/coord_y changing while not accepted has no effect.
- Reset mid-operation: immediate return to IDLE, rd_en drops asynchronously, no pixelx4_valid is produced for the aborted request.

Optional Feature:
- PIX_STATS_EN defined: adds outputs px_count[31:0] (increments on every pixelx4_valid) and oob_count[15:0] (increments on each oob emit). Both are cleared by rst and saturate at all-ones.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Interior sample, RD_LAT=2, memory data = address[15:0]. Stimulus: coord_x=0x00A80 (10.5), coord_y=0x01440 (20.25).
   Required response:
   - rd_addr 12810, 12811, 13450, 13451 on 4 consecutive cycles;
   - pixelx4_valid exactly 8 cycles after accept;
   - pixelx4={16'd13451,16'd13450,16'd12811,16'd12810};
   - decimal=16'h8040.
2. Corner clamp. Stimulus: xi=639, yi=479, fractions 0xFF.
   Required response: all four reads at address 307199; pixelx4 = that pixel ×4; decimal=16'hFFFF.
3. Out of range. Stimulus: coord_x=640<<8, BG_PIXEL=16'hF800.
   Required response: no rd_en; pixelx4_valid at accept+2; pixelx4=64'hF800F800F800F800; decimal=0.
4. Credit exhaustion. Stimulus: CREDITS=8, hold coord_valid, fifo_pop=0.
   Required response:
   - exactly 8 strobes, then coord_ready stays 0;
   - one fifo_pop reopens coord_ready the next cycle;
   - EMIT coincident with fifo_pop leaves credits unchanged.
5. Credit error. Stimulus: fifo_pop with credits full.
   Required response: credit_err=1 and stays 1; credits remains 8.
6. Reset mid-WAIT. Stimulus: assert rst 1 cycle after the last rd_en, then release.
   Required response: no pixelx4_valid; credits=8; the next request produces correct data with no stale slot contents.
